// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm melody player.
//   - state_e      : FSM state encoding (SNOOZE exists only with ALARM_SNOOZE_EN)
//   - NUM_NOTES    : melody length in notes
//   - HP_*         : note half-periods in clock cycles (0 = rest)
//   - is_active()  : true for states where the melody is sounding
// Configuration macro: ALARM_SNOOZE_EN adds the SNOOZE state.
package alarm_pkg;

    localparam int NUM_NOTES = 16;
    localparam int IDX_W     = 4;
    localparam int HP_W      = 16;
    // Wide enough to count note/gap lengths up to 2^20 cycles without wrapping.
    localparam int TIMER_W   = 21;

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_GAP    = 2'd2,
        ST_SNOOZE = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;
`endif

    localparam logic [HP_W-1:0] HP_REST = 16'd0;
    localparam logic [HP_W-1:0] HP_C    = 16'd3;
    localparam logic [HP_W-1:0] HP_D    = 16'd4;
    localparam logic [HP_W-1:0] HP_E    = 16'd5;
    localparam logic [HP_W-1:0] HP_F    = 16'd6;
    localparam logic [HP_W-1:0] HP_G    = 16'd7;
    localparam logic [HP_W-1:0] HP_A    = 16'd8;

    function automatic logic is_active(input state_e s);
        return (s == ST_PLAY) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/note_rom.sv
// note_rom: combinational melody table.
//   idx         in  4  melody note index
//   half_period out 16 tone half-period in clock cycles, 0 for a rest
module note_rom
    import alarm_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [HP_W-1:0]  half_period
);

    always_comb begin
        half_period = HP_REST;
        case (idx)
            4'd0:  half_period = HP_C;
            4'd1:  half_period = HP_E;
            4'd2:  half_period = HP_G;
            4'd3:  half_period = HP_REST;
            4'd4:  half_period = HP_G;
            4'd5:  half_period = HP_E;
            4'd6:  half_period = HP_C;
            4'd7:  half_period = HP_D;
            4'd8:  half_period = HP_E;
            4'd9:  half_period = HP_F;
            4'd10: half_period = HP_G;
            4'd11: half_period = HP_REST;
            4'd12: half_period = HP_A;
            4'd13: half_period = HP_G;
            4'd14: half_period = HP_E;
            4'd15: half_period = HP_C;
            default: half_period = HP_REST;
        endcase
    end

endmodule

// File: rtl/alarm_player.sv
// alarm_player: plays a 16-note square-wave melody while the alarm rings.
//   newclk   in  1  clock, all logic on its rising edge
//   rst      in  1  synchronous active-high reset
//   do_in    in  1  ring request level ("do"), high while ringing
//   stop     in  1  user stop switch, level-high
//   snooze   in  1  snooze request (only used with ALARM_SNOOZE_EN)
//   buzzer   out 1  square-wave tone
//   playing  out 1  high in PLAY and GAP
//   note_idx out 4  current melody note
//   done     out 1  one-cycle pulse on auto-stop after MAX_LOOPS passes
// Configuration macro: ALARM_SNOOZE_EN enables the SNOOZE state.
module alarm_player
    import alarm_pkg::*;
#(
    parameter int NOTE_TICKS   = 250,
    parameter int GAP_TICKS    = 25,
    parameter int MAX_LOOPS    = 4,
    parameter int SNOOZE_TICKS = 5000
) (
    input  logic             newclk,
    input  logic             rst,
    input  logic             do_in,
    input  logic             stop,
    input  logic             snooze,
    output logic             buzzer,
    output logic             playing,
    output logic [IDX_W-1:0] note_idx,
    output logic             done
);

    localparam int LOOP_W = $clog2(MAX_LOOPS + 1);

    state_e                  state_q, state_d;
    logic                    do_q;
    logic [TIMER_W-1:0]      tick_q, tick_d;
    logic [HP_W-1:0]         tone_q, tone_d;
    logic                    buzzer_q, buzzer_d;
    logic                    playing_q, playing_d;
    logic [IDX_W-1:0]        note_idx_q, note_idx_d;
    logic [LOOP_W-1:0]       loop_q, loop_d;
    logic [LOOP_W-1:0]       loop_next;
    logic                    done_q, done_d;
    logic [HP_W-1:0]         half_period;
    logic                    start;
    logic                    abort;

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = $clog2(SNOOZE_TICKS + 1);
    logic [SNZ_W-1:0]        snz_q, snz_d;
`else
    // The snooze input has no function in this build.
    logic                    snooze_unused;
    assign snooze_unused = snooze;
`endif

    note_rom u_note_rom (
        .idx         (note_idx_q),
        .half_period (half_period)
    );

    // do_q holds last cycle's ring level, so a rising ring edge is a start.
    assign start     = do_in & ~do_q;
    assign abort     = stop | ~do_in;
    assign loop_next = loop_q + LOOP_W'(1);

    // Next-state and output computation; every output is registered below.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        tone_d     = tone_q;
        buzzer_d   = buzzer_q;
        note_idx_d = note_idx_q;
        loop_d     = loop_q;
        done_d     = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_d      = snz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // stop asserted together with the ring edge keeps us idle
                if (start && !stop) begin
                    state_d    = ST_PLAY;
                    note_idx_d = '0;
                    loop_d     = '0;
                    tick_d     = '0;
                    tone_d     = '0;
                    buzzer_d   = 1'b0;
                end
            end
            ST_PLAY: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    buzzer_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_d  = ST_SNOOZE;
                    buzzer_d = 1'b0;
                    snz_d    = '0;
`endif
                end else if (tick_q == TIMER_W'(NOTE_TICKS - 1)) begin
                    state_d  = ST_GAP;
                    tick_d   = '0;
                    tone_d   = '0;
                    buzzer_d = 1'b0;
                end else begin
                    tick_d = tick_q + TIMER_W'(1);
                    // A rest note keeps the tone generator parked at zero.
                    if (half_period == HP_REST) begin
                        buzzer_d = 1'b0;
                        tone_d   = '0;
                    end else if (tone_q == half_period - HP_W'(1)) begin
                        buzzer_d = ~buzzer_q;
                        tone_d   = '0;
                    end else begin
                        tone_d = tone_q + HP_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    buzzer_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_d  = ST_SNOOZE;
                    buzzer_d = 1'b0;
                    snz_d    = '0;
`endif
                end else if (tick_q == TIMER_W'(GAP_TICKS - 1)) begin
                    tick_d   = '0;
                    tone_d   = '0;
                    buzzer_d = 1'b0;
                    if (note_idx_q == IDX_W'(NUM_NOTES - 1)) begin
                        note_idx_d = '0;
                        loop_d     = loop_next;
                        if (loop_next == LOOP_W'(MAX_LOOPS)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else begin
                        note_idx_d = note_idx_q + IDX_W'(1);
                        state_d    = ST_PLAY;
                    end
                end else begin
                    tick_d = tick_q + TIMER_W'(1);
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                // Snooze restarts the melody from the top but keeps the pass count.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (snz_q == SNZ_W'(SNOOZE_TICKS - 1)) begin
                    state_d    = ST_PLAY;
                    note_idx_d = '0;
                    tick_d     = '0;
                    tone_d     = '0;
                    buzzer_d   = 1'b0;
                end else begin
                    snz_d = snz_q + SNZ_W'(1);
                end
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                buzzer_d = 1'b0;
            end
        endcase
        playing_d = is_active(state_d);
    end

    // State register; reset overrides every other input.
    always_ff @(posedge newclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            do_q       <= 1'b0;
            tick_q     <= '0;
            tone_q     <= '0;
            buzzer_q   <= 1'b0;
            playing_q  <= 1'b0;
            note_idx_q <= '0;
            loop_q     <= '0;
            done_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            do_q       <= do_in;
            tick_q     <= tick_d;
            tone_q     <= tone_d;
            buzzer_q   <= buzzer_d;
            playing_q  <= playing_d;
            note_idx_q <= note_idx_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
`ifdef ALARM_SNOOZE_EN
            snz_q      <= snz_d;
`endif
        end
    end

    assign buzzer   = buzzer_q;
    assign playing  = playing_q;
    assign note_idx = note_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alarm_player.sv
// tb_alarm_player: scoreboard bench for alarm_player.
// The reference model tracks elapsed time since the melody started and derives
// note, tone phase and auto-stop from that count with plain arithmetic.
module tb_alarm_player;

    localparam int NT       = 8;
    localparam int GT       = 2;
    localparam int ML       = 1;
    localparam int SN       = 20;
    localparam int SLOT     = NT + GT;
    localparam int PASS_LEN = 16 * SLOT;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_ON = 1'b1;
`else
    localparam bit SNZ_ON = 1'b0;
`endif

    logic       newclk = 1'b0;
    logic       rst    = 1'b1;
    logic       do_in  = 1'b0;
    logic       stop   = 1'b0;
    logic       snooze = 1'b0;
    logic       buzzer;
    logic       playing;
    logic [3:0] note_idx;
    logic       done;

    always #5 newclk = ~newclk;

    alarm_player #(
        .NOTE_TICKS   (NT),
        .GAP_TICKS    (GT),
        .MAX_LOOPS    (ML),
        .SNOOZE_TICKS (SN)
    ) dut (
        .newclk   (newclk),
        .rst      (rst),
        .do_in    (do_in),
        .stop     (stop),
        .snooze   (snooze),
        .buzzer   (buzzer),
        .playing  (playing),
        .note_idx (note_idx),
        .done     (done)
    );

    typedef struct {
        logic       playing;
        logic       buzzer;
        logic [3:0] note;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Melody half-periods in cycles; 0 is a rest.
    int melody [16] = '{3, 5, 7, 0, 7, 5, 3, 4, 5, 6, 7, 0, 8, 7, 5, 3};

    // Model state: mode 0 idle, 1 sounding (play/gap), 2 snoozing.
    int m_mode  = 0;
    int m_t     = 0;
    int m_loops = 0;
    int m_snz   = 0;
    bit m_prev  = 1'b0;
    int m_note  = 0;
    bit m_done  = 1'b0;

    function automatic exp_t modelStep(input bit r, input bit d, input bit s, input bit z);
        exp_t e;
        int   phase;
        int   hp;
        if (r) begin
            m_mode = 0; m_t = 0; m_loops = 0; m_snz = 0;
            m_prev = 1'b0; m_note = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_mode)
                0: if (d && !m_prev && !s) begin
                       m_mode = 1; m_t = 0; m_loops = 0; m_note = 0;
                   end
                1: if (s || !d) begin
                       m_mode = 0;
                   end else if (SNZ_ON && z) begin
                       m_mode = 2; m_snz = 0;
                   end else begin
                       m_t++;
                       if (m_t == PASS_LEN) begin
                           m_t = 0;
                           m_loops++;
                           if (m_loops == ML) begin
                               m_mode = 0;
                               m_done = 1'b1;
                           end
                       end
                       m_note = m_t / SLOT;
                   end
                default: if (s || !d) begin
                       m_mode = 0;
                   end else begin
                       m_snz++;
                       if (m_snz == SN) begin
                           m_mode = 1; m_t = 0; m_note = 0;
                       end
                   end
            endcase
            m_prev = d;
        end
        phase     = m_t % SLOT;
        hp        = melody[m_t / SLOT];
        e.playing = (m_mode == 1);
        e.buzzer  = (m_mode == 1 && phase < NT && hp != 0) ? (((phase / hp) % 2) == 1) : 1'b0;
        e.note    = 4'(m_note);
        e.done    = m_done;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic applyStimulus(input bit r, input bit d, input bit s, input bit z);
        @(negedge newclk);
        rst    = r;
        do_in  = d;
        stop   = s;
        snooze = z;
        exp_q.push_back(modelStep(r, d, s, z));
    endtask

    task automatic checkBit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkBit("playing", playing, e.playing);
        checkBit("buzzer", buzzer, e.buzzer);
        checkBit("done", done, e.done);
        checks++;
        if (note_idx !== e.note) begin
            fails++;
            $display("[TB] FAIL note_idx at %0t: got %0d expected %0d", $time, note_idx, e.note);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge newclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic runCycles(input int n, input bit d, input bit s, input bit z);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, d, s, z);
    endtask

    initial begin
        // Reset, then idle with the alarm quiet.
        runCycles(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(6, 1'b0, 1'b0, 1'b0);

        // Full melody pass with do held high, auto-stop, and no restart while high.
        runCycles(PASS_LEN + 20, 1'b1, 1'b0, 1'b0);

        // Stop coinciding with the ring edge wins; staying high does not restart.
        runCycles(3, 1'b0, 1'b0, 1'b0);
        runCycles(1, 1'b1, 1'b1, 1'b0);
        runCycles(5, 1'b1, 1'b0, 1'b0);

        // Stop in the middle of a note.
        runCycles(2, 1'b0, 1'b0, 1'b0);
        runCycles(34, 1'b1, 1'b0, 1'b0);
        runCycles(1, 1'b1, 1'b1, 1'b0);
        runCycles(4, 1'b1, 1'b0, 1'b0);

        // Reset during note 5 with do held high, then restart on release.
        runCycles(2, 1'b0, 1'b0, 1'b0);
        runCycles(5 * SLOT + 3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        runCycles(45, 1'b1, 1'b0, 1'b0);

        // Snooze during note 2 (ignored when snooze is not built in).
        runCycles(2, 1'b0, 1'b0, 1'b0);
        runCycles(2 * SLOT + 3, 1'b1, 1'b0, 1'b0);
        runCycles(1, 1'b1, 1'b0, 1'b1);
        runCycles(SN + 15, 1'b1, 1'b0, 1'b0);
        runCycles(1, 1'b1, 1'b1, 1'b1);
        runCycles(3, 1'b1, 1'b0, 1'b0);

        // Random traffic: mostly ringing, with occasional drops, stops, snoozes, resets.
        begin
            bit d;
            d = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(63) == 0) d = ~d;
                applyStimulus($urandom_range(499) == 0, d,
                              $urandom_range(149) == 0, $urandom_range(79) == 0);
            end
        end

        @(posedge newclk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alarm_player.md
ALARM_PLAYER -- requirements
Module: alarm_player

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- NOTE_TICKS, 250, newclk cycles per note.
- GAP_TICKS, 25, silent cycles between notes.
- MAX_LOOPS, 4, melody passes before auto-stop.
- SNOOZE_TICKS, 5000, snooze wait in cycles.
REQ-002 SHALL have these ports (name, direction, width, meaning), one per line:
- newclk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- do  in  1  ring request level from the alarm block; high while ringing.
- stop  in  1  user switch; level-high stop.
- snooze  in  1  snooze request; used only when ALARM_SNOOZE_EN is defined, ignored otherwise.
- buzzer  out  1  square-wave tone output.
- playing  out  1  high in the PLAY and GAP states.
- note_idx  out  4  index of the current melody note.
- done  out  1  one-cycle pulse on auto-stop after MAX_LOOPS passes.

Function
REQ-003 SHALL register do into do_q every cycle; a start event is do=1 with do_q=0.
REQ-004 SHALL implement states IDLE, PLAY, GAP and, with the macro, SNOOZE.
REQ-005 IDLE->PLAY SHALL occur on a start event with stop=0; note_idx=0, loop=0, note timer=0, tone counter=0.
REQ-006 playing SHALL rise in the cycle after the edge that samples the start event; all outputs registered.
REQ-007 In PLAY, tone counter SHALL count to half_period(note_idx)-1, then toggle buzzer and clear to 0.
REQ-008 A rest note (half_period=0) SHALL hold buzzer at 0.
REQ-009 PLAY SHALL last exactly NOTE_TICKS cycles, then enter GAP with buzzer forced to 0.
REQ-010 GAP SHALL last exactly GAP_TICKS cycles, then enter PLAY with note_idx+1 and buzzer=0.
REQ-011 note_idx SHALL wrap 15->0 and increment loop; if the new loop equals MAX_LOOPS, go to IDLE and pulse done for 1 cycle.
REQ-012 From any non-IDLE state, stop=1 or do=0 SHALL force IDLE next cycle: buzzer=0, playing=0, no done pulse.
REQ-013 stop=1 coinciding with a start event SHALL win; the FSM stays in IDLE.
REQ-014 After auto-stop, no restart SHALL occur until do falls and rises again.
REQ-015 Tone and note timers SHALL be wide enough for half-periods up to 16 bits and NOTE_TICKS up to 2^20; no overflow wrap.

Reset
REQ-016 rst=1 SHALL, on the clock edge, set state=IDLE, buzzer=0, playing=0, note_idx=0, done=0, do_q=0, and clear all counters.
REQ-017 rst SHALL override every other input, including mid-note and mid-snooze.
REQ-018 do held high across reset release SHALL count as a start event, because do_q resets to 0.

Configuration
REQ-019 Macro ALARM_SNOOZE_EN defined: snooze=1 in PLAY or GAP SHALL enter SNOOZE (buzzer=0, playing=0).
- After SNOOZE_TICKS cycles, restart PLAY at note_idx=0; loop count is kept.
- stop=1 or do=0 in SNOOZE SHALL go to IDLE.
- stop and snooze asserted together: stop wins.
REQ-020 Macro ALARM_SNOOZE_EN undefined: the snooze port SHALL be ignored and the SNOOZE state and its counter SHALL not exist.

Structure
REQ-021 Shared package alarm_pkg SHALL hold the state encoding, NUM_NOTES=16, and named note half-period constants.
REQ-022 The melody SHALL sit in sub-module note_rom: combinational, 4-bit index in, 16-bit half_period out.

Verification (bench parameters NOTE_TICKS=8, GAP_TICKS=2, MAX_LOOPS=1; note0 half_period=3)
REQ-023 Start: do 0->1 at cycle 10 -> playing=1 at cycle 11; buzzer toggles every 3 cycles; note_idx=1 after 8+2 cycles.
REQ-024 Auto-stop: do held high -> after 16 notes, done pulses once, playing=0; no restart until do goes 0 then 1.
REQ-025 Stop priority: stop=1 in the same cycle as the do rise -> playing stays 0; stop=1 mid-note -> IDLE and buzzer=0 next cycle.
REQ-026 Reset mid-play: rst=1 at note_idx=5 -> all outputs 0 next cycle; rst released with do=1 -> playback restarts at note 0.
REQ-027 Rest note: ROM entry 0 at note 3 -> buzzer stays 0 for all 8 cycles of note 3.
REQ-028 Snooze (macro on, SNOOZE_TICKS=20): snooze=1 at note 2 -> silent for 20 cycles, then PLAY at note_idx=0.
